arbitro_de_funcionalidade: RTL and testbench

ARBITRO_DE_FUNCIONALIDADE -- requirements
Module: arbitro_de_funcionalidade

---
 rtl/arbitro_de_funcionalidade.sv | 201 ++++++++++++++++++++
 tb/tb_arbitro_de_funcionalidade.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/arbitro_de_funcionalidade.sv
// Two-slot function arbiter: permission check, per-function exclusivity, timed grants.
// Optional macro ARBITRO_JUSTO_EN adds a one-shot fairness override for same-function contests.
module arbitro_de_funcionalidade #(
    parameter int unsigned HOLD_CYCLES = 16
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       REQ0,
    input  logic       REQ1,
    input  logic [2:0] USER0,
    input  logic [2:0] USER1,
    input  logic [2:0] FUNC0,
    input  logic [2:0] FUNC1,
    output logic       GNT0,
    output logic       GNT1,
    output logic [2:0] FUNC_ATIVA0,
    output logic [2:0] FUNC_ATIVA1,
    output logic       SEL,
    output logic       NEGADO0,
    output logic       NEGADO1,
    output logic       OCUPADO
);

    typedef enum logic [2:0] {
        OCIOSO,
        CONCEDE_0,
        CONCEDE_1,
        CONCEDE_AMBOS,
        LIBERA
    } estado_t;

    localparam logic [15:0] LP_ULTIMO = 16'(HOLD_CYCLES - 1);

    estado_t     r_estado;
    logic [15:0] r_cnt;
    logic        r_gnt0;
    logic        r_gnt1;
    logic [2:0]  r_fa0;
    logic [2:0]  r_fa1;
    logic        r_sel;
    logic        r_neg0;
    logic        r_neg1;
    logic        r_ocup;

    logic w_perm0;
    logic w_perm1;
    logic w_neg0;
    logic w_neg1;
    logic w_ambos;
    logic w_disputa;
    logic w_vence1;
    logic w_so0;
    logic w_so1;
    logic w_act0;
    logic w_act1;
    logic w_fim;

    // Privileged functions (bit 2 set) are reserved for the admin user.
    assign w_perm0   = REQ0 && (!FUNC0[2] || (USER0 == 3'b000));
    assign w_perm1   = REQ1 && (!FUNC1[2] || (USER1 == 3'b000));
    assign w_neg0    = REQ0 && !w_perm0;
    assign w_neg1    = REQ1 && !w_perm1;
    assign w_ambos   = w_perm0 && w_perm1 && (FUNC0 != FUNC1);
    assign w_disputa = w_perm0 && w_perm1 && (FUNC0 == FUNC1);

`ifdef ARBITRO_JUSTO_EN
    logic r_justo_pend;
    logic r_justo_slot;

    // The recorded loser of the previous contest wins the next one once.
    assign w_vence1 = r_justo_pend ? r_justo_slot : (USER1 < USER0);
`else
    assign w_vence1 = (USER1 < USER0);
`endif

    assign w_so0  = (w_perm0 && !w_perm1) || (w_disputa && !w_vence1);
    assign w_so1  = (w_perm1 && !w_perm0) || (w_disputa && w_vence1);
    assign w_act0 = r_gnt0 && REQ0;
    assign w_act1 = r_gnt1 && REQ1;
    assign w_fim  = (r_cnt == LP_ULTIMO);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_estado <= OCIOSO;
            r_cnt    <= 16'd0;
            r_gnt0   <= 1'b0;
            r_gnt1   <= 1'b0;
            r_fa0    <= 3'b000;
            r_fa1    <= 3'b000;
            r_sel    <= 1'b0;
            r_neg0   <= 1'b0;
            r_neg1   <= 1'b0;
            r_ocup   <= 1'b0;
`ifdef ARBITRO_JUSTO_EN
            r_justo_pend <= 1'b0;
            r_justo_slot <= 1'b0;
`endif
        end else begin
            r_neg0 <= 1'b0;
            r_neg1 <= 1'b0;
            unique case (r_estado)
                OCIOSO: begin
                    r_neg0 <= w_neg0;
                    r_neg1 <= w_neg1;
                    r_cnt  <= 16'd0;
                    if (w_ambos) begin
                        r_estado <= CONCEDE_AMBOS;
                        r_gnt0   <= 1'b1;
                        r_gnt1   <= 1'b1;
                        r_fa0    <= FUNC0;
                        r_fa1    <= FUNC1;
                        r_sel    <= 1'b0;
                        r_ocup   <= 1'b1;
                    end else if (w_so0) begin
                        r_estado <= CONCEDE_0;
                        r_gnt0   <= 1'b1;
                        r_fa0    <= FUNC0;
                        r_sel    <= 1'b0;
                        r_ocup   <= 1'b1;
                    end else if (w_so1) begin
                        r_estado <= CONCEDE_1;
                        r_gnt1   <= 1'b1;
                        r_fa1    <= FUNC1;
                        r_sel    <= 1'b1;
                        r_ocup   <= 1'b1;
                    end
`ifdef ARBITRO_JUSTO_EN
                    if (w_disputa) begin
                        r_justo_pend <= !r_justo_pend;
                        r_justo_slot <= !w_vence1;
                    end
`endif
                end
                CONCEDE_0: begin
                    if (!REQ0 || w_fim) begin
                        r_estado <= LIBERA;
                        r_gnt0   <= 1'b0;
                        r_fa0    <= 3'b000;
                        r_cnt    <= 16'd0;
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end
                CONCEDE_1: begin
                    if (!REQ1 || w_fim) begin
                        r_estado <= LIBERA;
                        r_gnt1   <= 1'b0;
                        r_fa1    <= 3'b000;
                        r_sel    <= 1'b0;
                        r_cnt    <= 16'd0;
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                    end
                end
                CONCEDE_AMBOS: begin
                    if ((!w_act0 && !w_act1) || w_fim) begin
                        r_estado <= LIBERA;
                        r_gnt0   <= 1'b0;
                        r_gnt1   <= 1'b0;
                        r_fa0    <= 3'b000;
                        r_fa1    <= 3'b000;
                        r_cnt    <= 16'd0;
                    end else begin
                        r_cnt <= r_cnt + 16'd1;
                        if (!REQ0) begin
                            r_gnt0 <= 1'b0;
                            r_fa0  <= 3'b000;
                        end
                        if (!REQ1) begin
                            r_gnt1 <= 1'b0;
                            r_fa1  <= 3'b000;
                        end
                    end
                end
                LIBERA: begin
                    r_estado <= OCIOSO;
                    r_ocup   <= 1'b0;
                end
                default: begin
                    r_estado <= OCIOSO;
                    r_gnt0   <= 1'b0;
                    r_gnt1   <= 1'b0;
                    r_fa0    <= 3'b000;
                    r_fa1    <= 3'b000;
                    r_sel    <= 1'b0;
                    r_ocup   <= 1'b0;
                end
            endcase
        end
    end

    assign GNT0        = r_gnt0;
    assign GNT1        = r_gnt1;
    assign FUNC_ATIVA0 = r_fa0;
    assign FUNC_ATIVA1 = r_fa1;
    assign SEL         = r_sel;
    assign NEGADO0     = r_neg0;
    assign NEGADO1     = r_neg1;
    assign OCUPADO     = r_ocup;

endmodule

// File: tb/tb_arbitro_de_funcionalidade.sv
// Directed bench for arbitro_de_funcionalidade (HOLD_CYCLES = 16).
// Output word: {GNT0,GNT1,SEL,OCUPADO,NEGADO0,NEGADO1,FA0,FA1}.
module tb_arbitro_de_funcionalidade;

    logic       CLK = 1'b0;
    logic       RST;
    logic       REQ0, REQ1;
    logic [2:0] USER0, USER1, FUNC0, FUNC1;
    logic       GNT0, GNT1, SEL, NEGADO0, NEGADO1, OCUPADO;
    logic [2:0] FUNC_ATIVA0, FUNC_ATIVA1;

    int n_chk = 0;
    int n_err = 0;

    always #5 CLK = ~CLK;

    arbitro_de_funcionalidade #(.HOLD_CYCLES(16)) dut (
        .CLK(CLK), .RST(RST),
        .REQ0(REQ0), .REQ1(REQ1),
        .USER0(USER0), .USER1(USER1),
        .FUNC0(FUNC0), .FUNC1(FUNC1),
        .GNT0(GNT0), .GNT1(GNT1),
        .FUNC_ATIVA0(FUNC_ATIVA0), .FUNC_ATIVA1(FUNC_ATIVA1),
        .SEL(SEL), .NEGADO0(NEGADO0), .NEGADO1(NEGADO1),
        .OCUPADO(OCUPADO)
    );

    wire [11:0] w_obs = {GNT0, GNT1, SEL, OCUPADO, NEGADO0, NEGADO1,
                         FUNC_ATIVA0, FUNC_ATIVA1};

    function automatic logic [11:0] mk(input logic g0, input logic g1,
                                       input logic s, input logic oc,
                                       input logic n0, input logic n1,
                                       input logic [2:0] f0,
                                       input logic [2:0] f1);
        return {g0, g1, s, oc, n0, n1, f0, f1};
    endfunction

    task automatic chk(input string tag, input logic [11:0] obs,
                       input logic [11:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s got=%h want=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic reqs(input logic r0, input logic [2:0] u0,
                        input logic [2:0] f0, input logic r1,
                        input logic [2:0] u1, input logic [2:0] f1);
        REQ0 = r0; USER0 = u0; FUNC0 = f0;
        REQ1 = r1; USER1 = u1; FUNC1 = f1;
    endtask

    localparam logic [11:0] IDLE = 12'h000;
    localparam logic [11:0] LIB  = 12'h100;

    initial begin
        RST = 1'b1;
        reqs(0, 0, 0, 0, 0, 0);
        #2;
        chk("rst_async", w_obs, IDLE);
        tick();
        chk("rst_held", w_obs, IDLE);
        RST = 1'b0;

        // both permitted, different functions
        reqs(1, 3'd0, 3'd1, 1, 3'd2, 3'd2);
        tick();
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("ambos_c%0d", i), w_obs, mk(1, 1, 0, 1, 0, 0, 3'd1, 3'd2));
            tick();
        end
        chk("ambos_libera", w_obs, LIB);
        reqs(0, 0, 0, 0, 0, 0);
        tick();
        chk("ambos_idle", w_obs, IDLE);

        // same function, slot 1 has the lower user code; held for a rematch
        reqs(1, 3'd4, 3'd3, 1, 3'd1, 3'd3);
        tick();
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("prio_c%0d", i), w_obs, mk(0, 1, 1, 1, 0, 0, 3'd0, 3'd3));
            tick();
        end
        chk("prio_libera", w_obs, LIB);
        tick();
        chk("prio_idle", w_obs, IDLE);
        tick();
`ifdef ARBITRO_JUSTO_EN
        chk("rematch", w_obs, mk(1, 0, 0, 1, 0, 0, 3'd3, 3'd0));
`else
        chk("rematch", w_obs, mk(0, 1, 1, 1, 0, 0, 3'd0, 3'd3));
`endif
        reqs(0, 0, 0, 0, 0, 0);
        tick();
        chk("rematch_libera", w_obs, LIB);
        tick();
        chk("rematch_idle", w_obs, IDLE);

        // privileged function by a non-admin user is denied every idle cycle
        reqs(1, 3'd2, 3'd5, 0, 3'd0, 3'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("negado_c%0d", i), w_obs, mk(0, 0, 0, 0, 1, 0, 3'd0, 3'd0));
        end
        USER0 = 3'd0;
        tick();
        chk("admin_grant", w_obs, mk(1, 0, 0, 1, 0, 0, 3'd5, 3'd0));
        REQ0 = 1'b0;
        tick();
        chk("admin_libera", w_obs, LIB);
        tick();
        chk("admin_idle", w_obs, IDLE);

        // exclusive slot 0 dropped early
        reqs(1, 3'd3, 3'd2, 0, 3'd0, 3'd0);
        tick();
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("drop_c%0d", i), w_obs, mk(1, 0, 0, 1, 0, 0, 3'd2, 3'd0));
            tick();
        end
        REQ0 = 1'b0;
        chk("drop_c5", w_obs, mk(1, 0, 0, 1, 0, 0, 3'd2, 3'd0));
        tick();
        chk("drop_libera", w_obs, LIB);
        tick();
        chk("drop_idle", w_obs, IDLE);

        // denied slot 0 alongside a permitted slot 1
        reqs(1, 3'd1, 3'd4, 1, 3'd5, 3'd1);
        tick();
        chk("mix_grant", w_obs, mk(0, 1, 1, 1, 1, 0, 3'd0, 3'd1));
        tick();
        chk("mix_hold", w_obs, mk(0, 1, 1, 1, 0, 0, 3'd0, 3'd1));
        reqs(0, 0, 0, 0, 0, 0);
        tick();
        chk("mix_libera", w_obs, LIB);
        tick();
        chk("mix_idle", w_obs, IDLE);

        // shared grant, slots drop one at a time
        reqs(1, 3'd6, 3'd0, 1, 3'd7, 3'd3);
        tick();
        chk("split_grant", w_obs, mk(1, 1, 0, 1, 0, 0, 3'd0, 3'd3));
        REQ0 = 1'b0;
        tick();
        chk("split_drop0", w_obs, mk(0, 1, 0, 1, 0, 0, 3'd0, 3'd3));
        REQ1 = 1'b0;
        tick();
        chk("split_libera", w_obs, LIB);
        tick();
        chk("split_idle", w_obs, IDLE);

        // equal users on the same function: slot 0 wins the fresh contest
        reqs(1, 3'd3, 3'd2, 1, 3'd3, 3'd2);
        tick();
        chk("tie_grant", w_obs, mk(1, 0, 0, 1, 0, 0, 3'd2, 3'd0));
        reqs(0, 0, 0, 0, 0, 0);
        tick();
        chk("tie_libera", w_obs, LIB);
        tick();
        chk("tie_idle", w_obs, IDLE);

        // reset in the middle of an exclusive slot 1 grant
        reqs(0, 3'd0, 3'd0, 1, 3'd0, 3'd6);
        tick();
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("rgnt_c%0d", i), w_obs, mk(0, 1, 1, 1, 0, 0, 3'd0, 3'd6));
            tick();
        end
        #1 RST = 1'b1;
        #1;
        chk("rst_mid_async", w_obs, IDLE);
        tick();
        chk("rst_mid_held", w_obs, IDLE);
        RST = 1'b0;
        tick();
        chk("rst_regrant", w_obs, mk(0, 1, 1, 1, 0, 0, 3'd0, 3'd6));
        REQ1 = 1'b0;
        tick();
        chk("rst_libera", w_obs, LIB);
        tick();
        chk("rst_idle", w_obs, IDLE);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
